// File: rtl/nibble_serial_adder.sv
// Wide adder built from one external 4-bit adder, one nibble per clock.
// Optional SUB_EN macro adds in_sub for subtraction (a - b) via ~b + 1.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic [3:0]       nib_a,
    output logic [3:0]       nib_b,
    output logic             nib_cin,
    input  logic [3:0]       nib_sum,
    input  logic             nib_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             carry_init;
    logic [3:0]       b_nib;

`ifdef SUB_EN
    logic             sub_q;

    assign carry_init = in_sub ? 1'b1 : in_cin;
    assign b_nib      = sub_q ? ~b_q[{idx_q, 2'b00} +: 4]
                              :  b_q[{idx_q, 2'b00} +: 4];
`else
    assign carry_init = in_cin;
    assign b_nib      = b_q[{idx_q, 2'b00} +: 4];
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

    // The external adder sees only the current nibble; zero it when idle.
    always_comb begin
        nib_a   = 4'h0;
        nib_b   = 4'h0;
        nib_cin = 1'b0;
        sum_d   = sum_q;
        sum_d[{idx_q, 2'b00} +: 4] = nib_sum;
        if (state_q == S_RUN) begin
            nib_a   = a_q[{idx_q, 2'b00} +: 4];
            nib_b   = b_nib;
            nib_cin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= carry_init;
                        idx_q   <= '0;
`ifdef SUB_EN
                        sub_q   <= in_sub;
`endif
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= nib_cout;
                    if (idx_q == LAST) begin
                        cout_q  <= nib_cout;
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder.
// Models the external 4-bit adder and checks against plain integer sums.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             nib_cin;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // The external 4-bit ripple adder.
    assign {nib_cout, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {4'h0, nib_cin};

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
`ifdef SUB_EN
        .in_sub   (in_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .busy     (busy),
        .nib_a    (nib_a),
        .nib_b    (nib_b),
        .nib_cin  (nib_cin),
        .nib_sum  (nib_sum),
        .nib_cout (nib_cout)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input int hold, input string tag);
        logic [WIDTH:0] exp;
        int lat;
        int w;
        exp = model(a, b, cin);
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk({tag, "_ready"}, in_ready, 1'b1);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        chk({tag, "_busy"}, {busy, in_ready}, 2'b10);
        wait_valid(lat);
        chk({tag, "_lat"}, lat, NIB);
        chk({tag, "_sum"}, {out_cout, out_sum}, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold"}, {out_valid, out_cout, out_sum}, {1'b1, exp});
        end
        out_ready = 1'b1;
        tick();
        chk({tag, "_rel"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        logic [WIDTH:0] exp;
        int lat;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
`ifdef SUB_EN
        in_sub = 1'b0;
`endif
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out", {out_valid, out_cout, out_sum, busy}, '0);
        chk("rst_rdy", in_ready, 1'b1);
        chk("rst_nib", {nib_a, nib_b, nib_cin}, 9'h0);
        rst = 1'b0;
        tick();

        do_op(16'h1234, 16'h4321, 1'b0, 0, "d5555");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1, "ripple1");
        do_op(16'hFFFF, 16'h0000, 1'b1, 2, "ripple2");

        // Backpressure with new operands waiting.
        in_a = 16'h00FF;
        in_b = 16'h0001;
        in_cin = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_a = 16'h1111;
        in_b = 16'h2222;
        wait_valid(lat);
        chk("bp_lat", lat, NIB);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", {out_valid, in_ready, out_cout, out_sum},
                {2'b10, 17'h00100});
        end
        out_ready = 1'b1;
        tick();
        chk("bp_idle", {in_ready, out_valid}, 2'b10);
        tick();
        in_valid = 1'b0;
        chk("bp_acc", busy, 1'b1);
        wait_valid(lat);
        chk("bp_lat2", lat, NIB);
        chk("bp_sum2", {out_cout, out_sum}, 17'h03333);
        tick();

        // Reset while two nibbles into an operation.
        in_a = 16'hAAAA;
        in_b = 16'h5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_out", {out_valid, out_cout, out_sum, busy}, '0);
        chk("mr_rdy", {in_ready, nib_a, nib_b, nib_cin}, 10'h200);
        for (int i = 0; i < NIB + 2; i++) begin
            tick();
            chk("mr_novalid", out_valid, 1'b0);
        end
        do_op(16'h0001, 16'h0001, 1'b0, 0, "post_rst");

        // Randomized operands, carry-in and consumer stalls.
        for (int n = 0; n < 150; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (n % 7 == 0) rb = ~ra;
            do_op(ra, rb, 1'($urandom), $urandom_range(0, 3), "rand");
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                tick();
                chk("gap_idle", {in_ready, out_valid}, 2'b10);
            end
        end

`ifdef SUB_EN
        in_sub = 1'b1;
        in_a = 16'h0005;
        in_b = 16'h0007;
        in_cin = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        exp = {1'b0, 16'hFFFE};
        chk("sub_neg", {out_cout, out_sum}, exp);
        tick();
        in_a = 16'h0007;
        in_b = 16'h0005;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        exp = {1'b1, 16'h0002};
        chk("sub_pos", {out_cout, out_sum}, exp);
        tick();
        in_sub = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
